spi_flash_responder: RTL and testbench
======================================

Name: spi_flash_responder

Overview:
- SPI mode-0 slave that models a serial NOR flash. It is the responder end of the XIP read sequence the APB SPI master issues.
- It decodes the READ command (0x03) and the 24-bit address, fetches 32-bit words from a backing-memory port, and streams the bytes out on MISO with auto-incrementing address.
- It sits on the SoC SPI bus (ss[0]) in simulation and FPGA builds.
- All SPI pins are sampled synchronously in the system clock domain; no SCK-clocked flops.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on spi_sck, spi_ss_n and spi_mosi.
- CMD_READ, 8'h03, the only opcode served.
- ADDR_W, 24, address width carried in the command.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- spi_sck  in  1  SPI clock from the master; idle low.
- spi_ss_n  in  1  chip select, active low.
- spi_mosi  in  1  master-out data.
- spi_miso  out  1  slave-out data.
- mem_req  out  1  word fetch request; held until accepted.
- mem_addr  out  ADDR_W  word-aligned fetch address (bits [1:0] = 0).
- mem_valid  in  1  one-cycle pulse; mem_rdata is valid in that cycle.
- mem_rdata  in  32  fetched word; byte at addr+k is at [8k+7:8k].
- busy  out  1  high while chip select is active.
- underrun  out  1  one-cycle pulse when a data byte must start and its word is absent.

Behaviour:
- Reset (clock and reset are as decided): asynchronous, active low.
  - State = IDLE.
  - spi_miso=0, mem_req=0, mem_addr=0, busy=0, underrun=0.
  - Synchronizers preset: sck=0, ss_n=1.
- Edge detect: from the synchronized signals, derive sck_rise, sck_fall and ss_fall/ss_rise; each is a single-cycle strobe.
- Mode 0 timing: MOSI is sampled on sck_rise. MISO is updated on sck_fall, and also at data-phase entry.
- Timing requirement (documented, not checked by the block):
  - SCK high and low phases each at least SYNC_STAGES+3 clocks.
  - Memory latency must be at most (SCK low phase − 3) clocks.
  - The master's DIVIDER must be programmed accordingly.
- FSM states: IDLE, CMD, ADDR, FETCH, DATA, IGNORE.
- IDLE: on ss_fall → CMD, bit counter = 0, busy=1.
- CMD: shift 8 bits MSB-first.
  - On the 8th sck_rise: opcode == CMD_READ → ADDR; otherwise → IGNORE.
- ADDR: shift 24 bits MSB-first.
  - On the 24th sck_rise: latch addr and assert mem_req with mem_addr = {addr[23:2],2'b0}; → FETCH.
- FETCH: wait for mem_valid, then latch the word and drop mem_req → DATA.
  - If sck_fall arrives first: pulse underrun and drive MISO=0 for that byte.
  - mem_req stays asserted until the word arrives.
- DATA:
  - Shift register loaded with byte addr[1:0] of the word; bits go out MSB-first, bit 7 driven immediately on load.
  - After 8 sck_fall strobes, addr increments by 1 and the next byte loads.
  - When addr[1:0] wraps 3→0, a new fetch is issued for the next word (re-enter FETCH, same underrun rule).
  - Address wraps 24'hFFFFFF → 24'h000000.
- Byte order: little-endian memory order is kept. The first byte sent is the byte at the start address. The master therefore sees the first byte in its RX MSB bits; any byte swap is a driver matter.
- IGNORE: spi_miso=0, no mem_req, wait for ss_rise.
- Chip select release: ss_rise in any state →
  - IDLE, busy=0, spi_miso=0.
  - An outstanding mem_req drops; a late mem_valid is discarded.
  - A partially shifted cmd/addr is discarded.
- SCK activity: edges while ss_n is high are ignored.
- Simultaneous events: ss_rise beats sck edges in the same cycle. mem_valid and sck_fall in the same cycle count as data arriving in time.

Decomposition:
- Package spi_flash_pkg holds:
  - the state enum;
  - CMD_READ;
  - the command and address bit counts (8, 24).
- One sub-module, spi_pin_sync: SYNC_STAGES synchronizer plus edge detect for sck/ss_n/mosi. Its outputs are sck_rise, sck_fall, ss_active, ss_rise, mosi_s.

Test Plan:
- Read at 0x000000, word 0x44332211, 8 data bytes at SCK=clk/16 → MISO bytes 11,22,33,44 then the next word's bytes; mem_addr 0x000000 then 0x000004. This is the master's 64-bit transfer.
- Unaligned read at 0x000003 → first byte = word[31:24], next fetch at 0x000004 after 1 byte.
- Opcode 0x0B → no mem_req, MISO stays 0 for the whole frame, busy drops on ss_rise.
- ss_n deasserted after 12 address bits, then a new read at 0x000010 → the clean new frame returns correct data; no stale mem_req.
- mem_valid delayed past the first data sck_fall → underrun pulses once, that byte reads 0x00, later bytes are correct.
- Read at 0xFFFFFC for 8 bytes → fetches at 0xFFFFFC then 0x000000.
- Async reset asserted mid-DATA → all outputs go to reset values without a clock edge.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI NOR flash read responder.
// Holds the controller state encoding, opcode and phase lengths.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_FETCH,
    ST_DATA,
    ST_IGNORE
  } state_e;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam int         CMD_BITS  = 8;
  localparam int         ADDR_BITS = 24;

  function automatic logic [7:0] word_byte(
    input logic [31:0] w,
    input logic [1:0]  sel
  );
    return w[8*sel +: 8];
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronises the SPI pins into the system clock domain and
// derives single-cycle SCK and chip-select edge strobes.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic spi_sck,
  input  logic spi_ss_n,
  input  logic spi_mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic ss_active,
  output logic ss_rise,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sck_sr;
  logic [SYNC_STAGES-1:0] ss_sr;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic                   sck_d;
  logic                   ss_d;
  logic                   sck_s;
  logic                   ss_s;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sck_sr  <= '0;
      ss_sr   <= '1;
      mosi_sr <= '0;
      sck_d   <= 1'b0;
      ss_d    <= 1'b1;
    end else begin
      sck_sr  <= {sck_sr[SYNC_STAGES-2:0], spi_sck};
      ss_sr   <= {ss_sr[SYNC_STAGES-2:0], spi_ss_n};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
      sck_d   <= sck_s;
      ss_d    <= ss_s;
    end
  end

  assign sck_s     = sck_sr[SYNC_STAGES-1];
  assign ss_s      = ss_sr[SYNC_STAGES-1];
  assign mosi_s    = mosi_sr[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_d;
  assign sck_fall  = ~sck_s & sck_d;
  assign ss_active = ~ss_s;
  assign ss_rise   = ss_s & ~ss_d;

endmodule

// File: rtl/spi_flash_responder.sv
// Mode-0 SPI slave serving READ (0x03) from a word-wide backing memory,
// streaming bytes in address order with auto-increment and prefetch.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CMD_READ    = spi_flash_pkg::CMD_READ,
  parameter int         ADDR_W      = 24
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              spi_sck,
  input  logic              spi_ss_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              underrun
);

  logic sck_rise;
  logic sck_fall;
  logic ss_active;
  logic ss_rise;
  logic mosi_s;

  spi_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock    (clock),
    .reset_n  (reset_n),
    .spi_sck  (spi_sck),
    .spi_ss_n (spi_ss_n),
    .spi_mosi (spi_mosi),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .ss_active(ss_active),
    .ss_rise  (ss_rise),
    .mosi_s   (mosi_s)
  );

  state_e            state, state_n;
  logic [4:0]        bit_cnt, bit_cnt_n;
  logic [ADDR_W-1:0] sh, sh_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic              req_q, req_n;
  logic [ADDR_W-1:0] maddr_q, maddr_n;
  logic [31:0]       word_q, word_n;
  logic [2:0]        bcnt, bcnt_n;
  logic              pend, pend_n;
  logic              miss, miss_n;
  logic              tx_ok, tx_ok_n;
  logic              miso_q, miso_n;
  logic              ur_q, ur_n;
  logic [7:0]        cur_byte;

  logic rise;
  logic fall;
  logic in_xfer;
  logic byte_end;

  assign rise     = sck_rise & ss_active;
  assign fall     = sck_fall & ss_active;
  assign in_xfer  = (state == ST_FETCH) || (state == ST_DATA);
  // pend marks the fall that opens byte 0; later bytes end on the 8th fall
  assign byte_end = fall & ~pend & (bcnt == 3'd7);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      sh      <= '0;
      addr    <= '0;
      req_q   <= 1'b0;
      maddr_q <= '0;
      word_q  <= '0;
      bcnt    <= '0;
      pend    <= 1'b0;
      miss    <= 1'b0;
      tx_ok   <= 1'b0;
      miso_q  <= 1'b0;
      ur_q    <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      sh      <= sh_n;
      addr    <= addr_n;
      req_q   <= req_n;
      maddr_q <= maddr_n;
      word_q  <= word_n;
      bcnt    <= bcnt_n;
      pend    <= pend_n;
      miss    <= miss_n;
      tx_ok   <= tx_ok_n;
      miso_q  <= miso_n;
      ur_q    <= ur_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    sh_n      = sh;
    addr_n    = addr;
    req_n     = req_q;
    maddr_n   = maddr_q;
    word_n    = word_q;
    bcnt_n    = bcnt;
    pend_n    = pend;
    miss_n    = miss;
    tx_ok_n   = tx_ok;
    ur_n      = 1'b0;
    miso_n    = 1'b0;
    cur_byte  = '0;

    if (in_xfer && fall) begin
      if (pend) begin
        pend_n = 1'b0;
      end else if (bcnt == 3'd7) begin
        bcnt_n = '0;
        addr_n = addr + ADDR_W'(1);
      end else begin
        bcnt_n = bcnt + 3'd1;
      end
    end

    unique case (state)
      ST_IDLE: begin
        if (ss_active) begin
          state_n   = ST_CMD;
          bit_cnt_n = '0;
        end
      end
      ST_CMD: begin
        if (rise) begin
          sh_n      = {sh[ADDR_W-2:0], mosi_s};
          bit_cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == 5'(CMD_BITS - 1)) begin
            bit_cnt_n = '0;
            state_n   = (sh_n[7:0] == CMD_READ) ? ST_ADDR : ST_IGNORE;
          end
        end
      end
      ST_ADDR: begin
        if (rise) begin
          sh_n      = {sh[ADDR_W-2:0], mosi_s};
          bit_cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == 5'(ADDR_BITS - 1)) begin
            bit_cnt_n = '0;
            addr_n    = sh_n;
            req_n     = 1'b1;
            maddr_n   = {sh_n[ADDR_W-1:2], 2'b00};
            pend_n    = 1'b1;
            miss_n    = 1'b0;
            bcnt_n    = '0;
            tx_ok_n   = 1'b0;
            state_n   = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (mem_valid) begin
          word_n  = mem_rdata;
          req_n   = 1'b0;
          tx_ok_n = ~miss | byte_end;
          miss_n  = 1'b0;
          state_n = ST_DATA;
        end else if (fall && (!miss || byte_end)) begin
          ur_n   = 1'b1;
          miss_n = 1'b1;
        end
      end
      ST_DATA: begin
        if (byte_end) begin
          tx_ok_n = 1'b1;
          if (addr_n[1:0] == 2'b00) begin
            state_n = ST_FETCH;
            req_n   = 1'b1;
            maddr_n = {addr_n[ADDR_W-1:2], 2'b00};
            tx_ok_n = 1'b0;
          end
        end
      end
      ST_IGNORE: begin
      end
      default: state_n = ST_IDLE;
    endcase

    // chip-select release overrides any edge seen in the same cycle
    if (ss_rise) begin
      state_n   = ST_IDLE;
      req_n     = 1'b0;
      tx_ok_n   = 1'b0;
      pend_n    = 1'b0;
      miss_n    = 1'b0;
      bit_cnt_n = '0;
      ur_n      = 1'b0;
    end

    cur_byte = word_byte(word_n, addr_n[1:0]);
    miso_n   = (state_n == ST_DATA) & tx_ok_n & cur_byte[~bcnt_n];
  end

  assign spi_miso = miso_q;
  assign mem_req  = req_q;
  assign mem_addr = maddr_q;
  assign busy     = (state != ST_IDLE);
  assign underrun = ur_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: SPI master tasks, latency-programmable
// memory responder and queue scoreboards for bytes and fetch addresses.
module tb_spi_flash_responder;

  localparam int HALF = 8;

  logic        clock;
  logic        reset_n;
  logic        spi_sck;
  logic        spi_ss_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        underrun;

  spi_flash_responder dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .spi_sck  (spi_sck),
    .spi_ss_n (spi_ss_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_valid(mem_valid),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .underrun (underrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] fetch_q[$];
  logic [7:0]  exp_q[$];
  int          fetch_cnt;
  int          ur_cnt;
  int          first_lat;

  typedef struct {
    logic [7:0]  op;
    logic [23:0] addr;
    int          nbytes;
    int          lat;
    int          exp_ur;
    int          exp_nf;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input logic [23:0] a);
    logic [7:0] s;
    s = a[7:0] + 8'd1;
    return 8'(s * 8'h11);
  endfunction

  function automatic logic [31:0] word_at(input logic [23:0] a);
    return {byte_at(24'(a + 3)), byte_at(24'(a + 2)),
            byte_at(24'(a + 1)), byte_at(a)};
  endfunction

  // backing memory with programmable latency for the first fetch
  int   lat_cnt;
  logic served;
  always @(negedge clock) begin
    mem_valid = 1'b0;
    if (!reset_n || !mem_req) begin
      lat_cnt = 0;
      served  = 1'b0;
    end else if (!served) begin
      lat_cnt++;
      if (lat_cnt >= first_lat) begin
        mem_valid = 1'b1;
        mem_rdata = word_at(mem_addr);
        served    = 1'b1;
        lat_cnt   = 0;
        first_lat = 2;
      end
    end
  end

  logic req_d = 1'b0;
  always @(negedge clock) begin
    if (mem_req === 1'b1 && req_d === 1'b0) begin
      fetch_cnt++;
      if (fetch_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL fetch_unexpected: got addr %h, expected none",
                 mem_addr);
      end else begin
        check("fetch_addr", {8'h0, mem_addr}, {8'h0, fetch_q.pop_front()});
      end
    end
    if (underrun === 1'b1) ur_cnt++;
    req_d = mem_req;
  end

  task automatic xfer_bit(input logic b, output logic r);
    spi_mosi = b;
    repeat (HALF) @(negedge clock);
    r = spi_miso;
    spi_sck = 1'b1;
    repeat (HALF) @(negedge clock);
    spi_sck = 1'b0;
  endtask

  task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_miso"}, spi_miso, 0);
    check({tag, "_req"}, mem_req, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_underrun"}, underrun, 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [7:0]  rx;
    logic [23:0] a;
    logic [7:0]  e;
    first_lat = v.lat;
    ur_cnt    = 0;
    fetch_cnt = 0;
    if (v.op == 8'h03) begin
      fetch_q.push_back({v.addr[23:2], 2'b00});
      for (int k = 1; k <= v.nbytes; k++) begin
        a = 24'(v.addr + k);
        if (a[1:0] == 2'b00) fetch_q.push_back(a);
      end
    end
    for (int k = 0; k < v.nbytes; k++) begin
      a = 24'(v.addr + k);
      if (v.op != 8'h03 || (v.exp_ur != 0 && k == 0)) exp_q.push_back(8'h00);
      else exp_q.push_back(byte_at(a));
    end
    spi_ss_n = 1'b0;
    repeat (8) @(negedge clock);
    check($sformatf("v%0d_busy_on", idx), busy, 1);
    xfer_byte(v.op, rx);
    xfer_byte(v.addr[23:16], rx);
    xfer_byte(v.addr[15:8], rx);
    xfer_byte(v.addr[7:0], rx);
    for (int k = 0; k < v.nbytes; k++) begin
      xfer_byte(8'h00, rx);
      e = exp_q.pop_front();
      check($sformatf("v%0d_byte%0d", idx, k), rx, e);
    end
    repeat (HALF) @(negedge clock);
    spi_ss_n = 1'b1;
    repeat (8) @(negedge clock);
    check($sformatf("v%0d_busy_off", idx), busy, 0);
    check($sformatf("v%0d_req_off", idx), mem_req, 0);
    check($sformatf("v%0d_miso_off", idx), spi_miso, 0);
    check($sformatf("v%0d_underruns", idx), ur_cnt, v.exp_ur);
    check($sformatf("v%0d_fetches", idx), fetch_cnt, v.exp_nf);
    check($sformatf("v%0d_fetch_left", idx), fetch_q.size(), 0);
    fetch_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx;
    logic       r;
    vecs[0] = '{8'h03, 24'h000000, 8, 2, 0, 3};
    vecs[1] = '{8'h03, 24'h000003, 3, 2, 0, 2};
    vecs[2] = '{8'h0B, 24'h000000, 4, 2, 0, 0};
    vecs[3] = '{8'h03, 24'h000000, 4, 20, 1, 2};
    vecs[4] = '{8'h03, 24'hFFFFFC, 8, 2, 0, 3};

    first_lat = 2;
    fetch_cnt = 0;
    ur_cnt    = 0;
    reset_n   = 1'b0;
    spi_sck   = 1'b0;
    spi_ss_n  = 1'b1;
    spi_mosi  = 1'b0;
    mem_rdata = '0;
    #1;
    check_reset_outs("rst0");
    repeat (4) @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // frame aborted after 12 address bits, then a clean read
    fetch_cnt = 0;
    spi_ss_n  = 1'b0;
    repeat (8) @(negedge clock);
    xfer_byte(8'h03, rx);
    for (int i = 0; i < 12; i++) xfer_bit(1'b1, r);
    repeat (HALF) @(negedge clock);
    spi_ss_n = 1'b1;
    repeat (8) @(negedge clock);
    check("abort_req", mem_req, 0);
    check("abort_busy", busy, 0);
    check("abort_fetches", fetch_cnt, 0);
    run_vec('{8'h03, 24'h000010, 4, 2, 0, 2}, 5);

    // asynchronous reset in the middle of the data phase
    first_lat = 2;
    fetch_cnt = 0;
    fetch_q.push_back(24'h000024);
    spi_ss_n = 1'b0;
    repeat (8) @(negedge clock);
    xfer_byte(8'h03, rx);
    xfer_byte(8'h00, rx);
    xfer_byte(8'h00, rx);
    xfer_byte(8'h24, rx);
    xfer_byte(8'h00, rx);
    check("mid_byte0", rx, byte_at(24'h000024));
    for (int i = 0; i < 3; i++) xfer_bit(1'b0, r);
    check("mid_busy", busy, 1);
    check("mid_addr", {8'h0, mem_addr}, 32'h24);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_outs("arst");
    spi_ss_n = 1'b1;
    spi_sck  = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    check("arst_after_busy", busy, 0);
    check("arst_fetch_left", fetch_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
